// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared definitions for the keypad matrix scanner: FSM encoding and key-code sizing.
package keypad_matrix_scanner_pkg;

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      CHECK = 2'd1,
      EMIT  = 2'd2
   } state_e;

   // Key-code width; a one- or two-key matrix still needs one code bit.
   function automatic int kw_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Event word layout is {release, code}, release in the MSB.
   function automatic int evt_w_f(input int n);
      return kw_f(n) + 1;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is accepted only
// when the head is popped in the same cycle, otherwise it is dropped.
module keypad_event_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             full,
   output logic             drop
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic             do_pop;
   logic             do_push;

   assign valid   = (cnt_q != '0);
   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && valid;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign dout    = mem_q[rd_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: clock-enabled column scan, whole-frame debounce and an
// ascending-code press/release walk feeding the event FIFO.
module keypad_matrix_scanner
   import keypad_matrix_scanner_pkg::*;
#(
   parameter int ROWS       = 3,
   parameter int COLS       = 3,
   parameter int SCAN_DIV   = 5000,
   parameter int DEB_FRAMES = 3,
   parameter int FIFO_DEPTH = 8,
   localparam int N         = ROWS * COLS,
   localparam int KW        = kw_f(N)
) (
   input  logic            clk,
   input  logic            clear,
   input  logic [ROWS-1:0] row_n,
   output logic [COLS-1:0] col_n,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [KW-1:0]   evt_code,
   output logic            evt_release,
   output logic            overflow,
   input  logic            clr_overflow,
   output logic [N-1:0]    key_state,
   output logic            any_key,
   output state_e          dbg_state_o
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SW = $clog2(DEB_FRAMES + 1);

   logic [ROWS-1:0] row_s1_q, row_s2_q, rows_act;
   logic [DW-1:0]   div_q, div_d;
   logic [CW-1:0]   col_q, col_d;
   logic [COLS-1:0] col_n_q, col_n_d;
   logic [N-1:0]    snap_q, snap_d, prev_q, prev_d;
   logic [N-1:0]    pending_q, pending_d, key_q, key_d;
   logic [SW-1:0]   stable_q, stable_d;
   logic [KW-1:0]   idx_q, idx_d;
   state_e          state_q, state_d;
   logic            ovf_q, ovf_d;
   logic            tick, last_col;
   logic            push, pop, fifo_valid, fifo_drop, full_unused;
   logic [KW:0]     push_data, head;

   assign rows_act = ~row_s2_q;
   assign tick     = (div_q == DW'(SCAN_DIV - 1));
   assign last_col = (col_q == CW'(COLS - 1));

   always_comb begin
      div_d   = tick ? '0 : div_q + 1'b1;
      col_d   = col_q;
      snap_d  = snap_q;
      col_n_d = '1;
      if (tick) begin
         for (int c = 0; c < COLS; c++) begin
            if (col_q == CW'(c)) snap_d[c*ROWS +: ROWS] = rows_act;
         end
         col_d = last_col ? '0 : col_q + 1'b1;
      end
      // Register the pin drive so the column moves exactly one cycle after tick.
      for (int c = 0; c < COLS; c++) col_n_d[c] = (col_d != CW'(c));
   end

   always_comb begin
      state_d   = state_q;
      stable_d  = stable_q;
      prev_d    = prev_q;
      pending_d = pending_q;
      idx_d     = idx_q;
      key_d     = key_q;
      push      = 1'b0;
      push_data = '0;
      case (state_q)
         SCAN: begin
            if (tick && last_col) state_d = CHECK;
         end
         CHECK: begin
            if (snap_q == prev_q)
               stable_d = (stable_q == SW'(DEB_FRAMES)) ? stable_q : stable_q + 1'b1;
            else
               stable_d = SW'(1);
            prev_d = snap_q;
            if ((stable_d >= SW'(DEB_FRAMES)) && (snap_q != key_q)) begin
               state_d   = EMIT;
               idx_d     = '0;
               pending_d = snap_q;
            end else begin
               state_d = SCAN;
            end
         end
         EMIT: begin
            if (pending_q[idx_q] != key_q[idx_q]) begin
               push         = 1'b1;
               push_data    = {key_q[idx_q], idx_q};
               key_d[idx_q] = pending_q[idx_q];
            end
            if (idx_q == KW'(N - 1)) state_d = SCAN;
            else                     idx_d   = idx_q + 1'b1;
         end
         default: state_d = SCAN;
      endcase
   end

   // A drop outranks a simultaneous clear so no lost event goes unreported.
   assign ovf_d = fifo_drop ? 1'b1 : (clr_overflow ? 1'b0 : ovf_q);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         row_s1_q  <= '1;
         row_s2_q  <= '1;
         div_q     <= '0;
         col_q     <= '0;
         col_n_q   <= ~COLS'(1);
         snap_q    <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         key_q     <= '0;
         stable_q  <= '0;
         idx_q     <= '0;
         state_q   <= SCAN;
         ovf_q     <= 1'b0;
      end else begin
         row_s1_q  <= row_n;
         row_s2_q  <= row_s1_q;
         div_q     <= div_d;
         col_q     <= col_d;
         col_n_q   <= col_n_d;
         snap_q    <= snap_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         key_q     <= key_d;
         stable_q  <= stable_d;
         idx_q     <= idx_d;
         state_q   <= state_d;
         ovf_q     <= ovf_d;
      end
   end

   assign pop = fifo_valid && evt_ready;

   keypad_event_fifo #(
      .WIDTH (KW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .clear (clear),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .valid (fifo_valid),
      .full  (full_unused),
      .drop  (fifo_drop)
   );

   assign col_n       = col_n_q;
   assign evt_valid   = fifo_valid;
   assign evt_release = head[KW];
   assign evt_code    = head[KW-1:0];
   assign overflow    = ovf_q;
   assign key_state   = key_q;
   assign any_key     = |key_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a frame-level model of debounce and event
// generation, a per-cycle compare process, directed scenarios and random frames.
module tb_keypad_matrix_scanner;
   import keypad_matrix_scanner_pkg::*;

   localparam int ROWS  = 3;
   localparam int COLS  = 3;
   localparam int SDIV  = 4;
   localparam int DEB   = 2;
   localparam int DEPTH = 4;
   localparam int N     = ROWS * COLS;
   localparam int KW    = 4;
   localparam int RDY_LOW    = 0;
   localparam int RDY_HIGH   = 1;
   localparam int RDY_TOGGLE = 2;

   logic            clk = 1'b0;
   logic            clear;
   logic [ROWS-1:0] row_n;
   logic [COLS-1:0] col_n;
   logic            evt_valid;
   logic            evt_ready;
   logic [KW-1:0]   evt_code;
   logic            evt_release;
   logic            overflow;
   logic            clr_overflow;
   logic [N-1:0]    key_state;
   logic            any_key;
   state_e          dbg_state;

   logic [N-1:0]    keys;
   int              ready_mode = RDY_HIGH;
   int              n_checks = 0;
   int              n_pass = 0;

   logic [KW:0]     exp_q[$];
   logic [KW:0]     got_q[$];
   logic [N-1:0]    m_prev, m_ks;
   int              m_stable;
   logic            m_ovf;

   keypad_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEB_FRAMES(DEB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .clear(clear), .row_n(row_n), .col_n(col_n),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
      .evt_release(evt_release), .overflow(overflow), .clr_overflow(clr_overflow),
      .key_state(key_state), .any_key(any_key), .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Physical key matrix: a closed key pulls its row low while its column is driven.
   always_comb begin
      row_n = '1;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (!col_n[c] && keys[c*ROWS + r]) row_n[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic model_reset();
      m_prev   = '0;
      m_ks     = '0;
      m_stable = 0;
      m_ovf    = 1'b0;
      exp_q.delete();
   endtask

   // One complete frame f: debounce count, then commit key by key in code order.
   task automatic model_frame(input logic [N-1:0] f);
      if (f == m_prev) m_stable = (m_stable < DEB) ? m_stable + 1 : DEB;
      else             m_stable = 1;
      m_prev = f;
      if (m_stable >= DEB && f != m_ks) begin
         for (int k = 0; k < N; k++) begin
            if (f[k] != m_ks[k]) begin
               if (ready_mode == RDY_LOW && exp_q.size() >= DEPTH) m_ovf = 1'b1;
               else exp_q.push_back({m_ks[k], 4'(k)});
            end
         end
         m_ks = f;
      end
   endtask

   // Hold keys for one whole frame, ending at the cycle column 0 is driven again.
   task automatic run_frame(input logic [N-1:0] k);
      logic [COLS-1:0] prev_c;
      bit seen;
      seen   = 0;
      keys   = k;
      prev_c = col_n;
      for (int i = 0; i < 4 * COLS * SDIV && !seen; i++) begin
         @(negedge clk);
         if (prev_c == 3'b011 && col_n == 3'b110) seen = 1;
         prev_c = col_n;
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL frame_timeout: no frame boundary within budget, expected one");
      end
      model_frame(k);
   endtask

   // Popped-event log against up to four literal events, first event in bits [4:0].
   task automatic check_log(input string name, input int n, input logic [19:0] evs);
      check({name, "_count"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++)
         check({name, "_evt"}, got_q[i], evs[i*5 +: 5]);
   endtask

   initial begin
      evt_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            RDY_LOW:  evt_ready = 1'b0;
            RDY_HIGH: evt_ready = 1'b1;
            default:  evt_ready = ~evt_ready;
         endcase
      end
   end

   // Every cycle out of reset: any_key consistency and each handshake vs the model.
   initial begin
      logic [KW:0] got;
      forever begin
         @(negedge clk);
         if (clear) begin
            check("any_key", any_key, |key_state);
            if (evt_valid && evt_ready) begin
               got = {evt_release, evt_code};
               got_q.push_back(got);
               if (exp_q.size() == 0) check("unexpected_event", got, 5'h1f ^ got);
               else check("event", got, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] rk;
      int hold;
      keys = '0;
      clr_overflow = 1'b0;
      clear = 1'b0;
      model_reset();
      #23;
      check("rst_col_n", col_n, 3'b110);
      check("rst_valid", evt_valid, 0);
      check("rst_key_state", key_state, 0);
      check("rst_overflow", overflow, 0);
      check("rst_any_key", any_key, 0);
      check("rst_fsm", dbg_state, SCAN);
      @(negedge clk);
      clear = 1'b1;
      repeat (2) run_frame('0);

      // Single press and release of key 5.
      got_q.delete();
      repeat (3) run_frame(9'h020);
      check("press5_state", key_state, 9'h020);
      check("press5_any", any_key, 1);
      check_log("press5", 1, 20'h00005);
      got_q.delete();
      repeat (3) run_frame('0);
      check("release5_state", key_state, 0);
      check_log("release5", 1, 20'h00015);

      // Bouncing key 2, then held.
      got_q.delete();
      for (int i = 0; i < 4; i++) run_frame((i % 2 == 0) ? 9'h004 : 9'h000);
      check_log("bounce_quiet", 0, 20'h0);
      repeat (3) run_frame(9'h004);
      check_log("bounce_press", 1, 20'h00002);
      check("bounce_state", key_state, 9'h004);
      repeat (3) run_frame('0);

      // Keys 7, 1, 4 together.
      got_q.delete();
      repeat (3) run_frame(9'h092);
      check_log("multi", 3, {5'h07, 5'h04, 5'h01});
      check("multi_state", key_state, 9'h092);
      repeat (3) run_frame('0);

      // Same keys with a toggling consumer.
      ready_mode = RDY_TOGGLE;
      got_q.delete();
      repeat (4) run_frame(9'h092);
      check_log("toggle", 3, {5'h07, 5'h04, 5'h01});
      check("toggle_drained", exp_q.size(), 0);
      ready_mode = RDY_HIGH;
      repeat (3) run_frame('0);
      check("toggle_rel_state", key_state, 0);
      check("toggle_rel_drained", exp_q.size(), 0);

      // Overflow with a stalled consumer.
      ready_mode = RDY_LOW;
      got_q.delete();
      repeat (3) run_frame(9'h03F);
      check("ovf_set", overflow, 1);
      check("ovf_model", overflow, m_ovf);
      check("ovf_state", key_state, 9'h03F);
      check("ovf_valid", evt_valid, 1);
      check("ovf_queued", exp_q.size(), 4);
      @(negedge clk);
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      m_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      ready_mode = RDY_HIGH;
      repeat (8) @(negedge clk);
      check_log("drain", 4, {5'h03, 5'h02, 5'h01, 5'h00});
      check("drain_empty", evt_valid, 0);
      run_frame(9'h03F);
      repeat (3) run_frame('0);
      check("drain_rel_state", key_state, 0);
      check("drain_rel_drained", exp_q.size(), 0);

      // Asynchronous reset in the middle of a frame with a full FIFO.
      ready_mode = RDY_LOW;
      repeat (3) run_frame(9'h1FF);
      check("pre_rst_ovf", overflow, 1);
      check("pre_rst_state", key_state, 9'h1FF);
      repeat (5) @(negedge clk);
      #3;
      clear = 1'b0;
      #1;
      check("mid_rst_col_n", col_n, 3'b110);
      check("mid_rst_valid", evt_valid, 0);
      check("mid_rst_state", key_state, 0);
      check("mid_rst_ovf", overflow, 0);
      check("mid_rst_any", any_key, 0);
      keys = '0;
      model_reset();
      ready_mode = RDY_HIGH;
      @(negedge clk);
      clear = 1'b1;
      got_q.delete();
      repeat (3) run_frame('0);
      check_log("post_rst", 0, 20'h0);

      // Random key frames, each held one to three frames.
      for (int i = 0; i < 25; i++) begin
         rk = N'($urandom_range(0, 511));
         hold = $urandom_range(1, 3);
         repeat (hold) run_frame(rk);
      end
      repeat (2) run_frame(keys);
      check("rand_state", key_state, m_ks);
      check("rand_drained", exp_q.size(), 0);
      check("rand_ovf", overflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised, single-clock successor to the fixed 3-row keypad controller. Scans a ROWS x COLS active-low key matrix, debounces the whole matrix frame by frame, and reports press and release events through a FIFO with a valid/ready handshake. It sits between the keypad pins and the game logic, replacing the derived-clock scanner with clock enables.

Parameters:
ROWS, 3, number of row inputs (≥1)
COLS, 3, number of driven columns (≥1)
SCAN_DIV, 5000, clk cycles per column slot (≥4)
DEB_FRAMES, 3, consecutive identical frames required to commit (≥1)
FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2)
Derived: N=ROWS*COLS; KW=max(1,clog2(N)). Constraint: SCAN_DIV*COLS ≥ N+4.

Ports:
clk  in  1  system clock
clear  in  1  reset, asynchronous assert, active-low
row_n  in  ROWS  raw row lines, low = key closed on the driven column
col_n  out  COLS  column drive, one-hot low
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts the head
evt_code  out  KW  key code of the head event
evt_release  out  1  1 = release event, 0 = press event
overflow  out  1  sticky: an event was dropped
clr_overflow  in  1  synchronous clear of overflow
key_state  out  N  debounced state, bit k = key k held
any_key  out  1  OR of key_state

Behaviour:
- Reset (clear low, async): col_n = ~1 (column 0 driven); evt_valid=0; overflow=0; key_state=0; any_key=0; FIFO empty; all counters 0; FSM = SCAN.
- Input sync: row_n passes through a 2-flop synchroniser and is inverted to active-high.
- Tick: div counter runs 0..SCAN_DIV-1. tick=1 when the counter equals SCAN_DIV-1.
- Column slot: column c is driven for exactly SCAN_DIV cycles. On tick, the synced rows are written into snapshot bits [c*ROWS +: ROWS] and c advances, wrapping COLS-1→0. col_n updates on the cycle after tick.
- Key code = col*ROWS + row (column-major, same ordering as the legacy {column,row} code).
- Frame end: tick with c=COLS-1. The FSM moves SCAN→CHECK for one cycle. Column scanning never pauses.
- CHECK:
  - If snapshot == prev_snapshot, stable_cnt increments, saturating at DEB_FRAMES. Otherwise stable_cnt = 1.
  - prev_snapshot <= snapshot.
  - If stable_cnt (updated value) ≥ DEB_FRAMES and snapshot != key_state, go to EMIT with idx=0 and pending=snapshot. Otherwise go to SCAN.
  - DEB_FRAMES=1 commits every frame.
- EMIT: one idx per cycle, 0..N-1.
  - If pending[idx] != key_state[idx], push {release=key_state[idx], code=idx} and set key_state[idx]=pending[idx].
  - After idx=N-1, return to SCAN.
  - Events come out in ascending code order, with presses and releases intermixed.
- key_state bits change only in EMIT. any_key is combinational from key_state.
- FIFO behaviour:
  - First-word fall-through: evt_* show the head whenever evt_valid=1.
  - Pop when evt_valid && evt_ready.
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - A push while full with no pop drops the event and sets overflow. key_state still updates.
  - Simultaneous push and pop on an empty FIFO: the push is accepted, evt_valid rises next cycle.
- overflow: clr_overflow clears it. A drop in the same cycle as clr_overflow wins (overflow stays 1).
- Mid-operation reset: FIFO contents, key_state and the EMIT walk are discarded immediately. No events are generated by the reset itself.
- Latency: after a clean press stable from frame f, the event is pushed at the CHECK of frame f+DEB_FRAMES-1 plus code+1 cycles. evt_valid follows one cycle later.

Decomposition:
- Shared header keypad_defs.vh holds:
  - the key-code width function (clog2);
  - the event field layout {release, code};
  - FSM state encodings SCAN=0, CHECK=1, EMIT=2.
- One sub-module, keypad_event_fifo (WIDTH=KW+1, DEPTH), is parametrised FWFT. It has clk, clear, push, din, pop, dout, valid, full and drop outputs.
- Scanner, debounce and FSM stay in keypad_matrix_scanner.

Test Plan:
Common setup: ROWS=3, COLS=3, SCAN_DIV=4, DEB_FRAMES=2, FIFO_DEPTH=4. One frame = 12 clk.
1. Reset: clear low mid-frame → col_n=3'b110, evt_valid=0, key_state=0, overflow=0 within the same cycle (asynchronous).
2. Single press: key 5 (col 1, row 2) held 3 frames with evt_ready=1 → exactly one event {release=0, code=5}, key_state=9'h020. Released for 3 frames → {release=1, code=5}, key_state=0.
3. Bounce: key 2 toggling every frame for 4 frames, then held 3 frames → no events during toggling, then one press event code=2.
4. Multi-key: keys 7, 1 and 4 pressed in the same frame → events in order codes 1, 4, 7, all release=0.
5. Overflow: evt_ready=0; keys 0-5 pressed together → 4 events queued, overflow=1, key_state=9'h03F. Pulse clr_overflow → overflow=0. Drain → codes 0, 1, 2, 3.
6. Handshake: evt_ready toggling 1/0 each cycle during case 4 → each event is popped exactly once, and order and values are unchanged.
